// File: rtl/mv_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// mv_job_arbiter_if : requester, engine and result signals of mv_job_arbiter
// Revision: 1.0
// ============================================================================
interface mv_job_arbiter_if;
  logic        s0_valid;
  logic [7:0]  s0_data;
  logic        s0_busy;
  logic        s1_valid;
  logic [7:0]  s1_data;
  logic        s1_busy;
  logic [1:0]  grant;
  logic        eng_start;
  logic [7:0]  eng_in;
  logic        eng_ready;
  logic [17:0] eng_out;
  logic [1:0]  res_valid;
  logic [17:0] res_data;
  logic [1:0]  res_idx;
  logic        res_err;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, eng_ready, eng_out,
    input  s0_busy, s1_busy, grant, eng_start, eng_in,
           res_valid, res_data, res_idx, res_err
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, eng_ready, eng_out,
    output s0_busy, s1_busy, grant, eng_start, eng_in,
           res_valid, res_data, res_idx, res_err
  );
endinterface
`default_nettype wire

// File: rtl/mv_job_arbiter.sv
`default_nettype none
// ============================================================================
// mv_job_arbiter : round-robin sharing of one serial matrix-vector engine
//                  between two 12-byte job buffers, with result routing
// Revision: 1.0
// ============================================================================
module mv_job_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  mv_job_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        owner, owner_n;
  logic        rr_ptr, rr_ptr_n;
  logic [3:0]  bc, bc_n;
  logic [1:0]  rc, rc_n;
  logic [7:0]  timer, timer_n;

  logic [1:0]  grant_q, grant_n;
  logic        eng_start_q, eng_start_n;
  logic [7:0]  eng_in_q, eng_in_n;
  logic [1:0]  res_valid_q, res_valid_n;
  logic [17:0] res_data_q, res_data_n;
  logic [1:0]  res_idx_q, res_idx_n;
  logic        res_err_q, res_err_n;

  logic [1:0]      wr_valid;
  logic [1:0][7:0] wr_data;
  logic [1:0][7:0] rd_byte;
  logic [1:0]      full;
  logic [1:0]      busy_w;
  logic            release_buf;

  assign wr_valid    = {bus.s1_valid, bus.s0_valid};
  assign wr_data     = {bus.s1_data, bus.s0_data};
  assign release_buf = (state == ST_DONE);

  for (genvar i = 0; i < 2; i++) begin : g_req
    localparam logic ID = 1'(i);
    logic [3:0] wc, wc_n;
    logic [7:0] mem [12];
    logic       busy;
    logic       accept;

    assign accept = wr_valid[i] && (wc < 4'd12);

    // The owner's count stays at 12 until DONE, so its writes are dropped
    // for the whole job including the DONE cycle itself.
    always_comb begin
      wc_n = wc;
      if (release_buf && (owner == ID)) begin
        wc_n = 4'd0;
      end else if (accept) begin
        wc_n = wc + 4'd1;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wc   <= 4'd0;
        busy <= 1'b0;
      end else begin
        wc   <= wc_n;
        busy <= (wc_n == 4'd12);
      end
    end

    always_ff @(posedge clock) begin
      if (accept) begin
        mem[wc] <= wr_data[i];
      end
    end

    assign full[i]    = (wc == 4'd12);
    assign busy_w[i]  = busy;
    assign rd_byte[i] = mem[bc];
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    bc_n        = bc;
    rc_n        = rc;
    timer_n     = timer;
    grant_n     = grant_q;
    eng_start_n = 1'b0;
    eng_in_n    = 8'd0;
    res_valid_n = 2'b00;
    res_data_n  = 18'd0;
    res_idx_n   = 2'd0;
    res_err_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (full != 2'b00) begin
          if (full == 2'b11) begin
            owner_n  = rr_ptr;
            rr_ptr_n = ~rr_ptr;
          end else begin
            owner_n = full[1];
          end
          grant_n = owner_n ? 2'b10 : 2'b01;
          bc_n    = 4'd0;
          rc_n    = 2'd0;
          state_n = ST_FEED;
        end
      end
      ST_FEED: begin
        eng_start_n = 1'b1;
        eng_in_n    = rd_byte[owner];
        bc_n        = bc + 4'd1;
        if (bc == 4'd11) begin
          bc_n    = 4'd0;
          timer_n = 8'd0;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT, ST_DRAIN: begin
        if (bus.eng_ready) begin
          res_valid_n = grant_q;
          res_data_n  = bus.eng_out;
          res_idx_n   = rc;
          rc_n        = rc + 2'd1;
          timer_n     = 8'd0;
          state_n     = (rc == 2'd3) ? ST_DONE : ST_DRAIN;
        end else if (timer == TIMEOUT_LAST) begin
          // Error pulse is registered here so it is visible during ERR.
          res_valid_n = grant_q;
          res_err_n   = 1'b1;
          res_idx_n   = rc;
          timer_n     = timer + 8'd1;
          state_n     = ST_ERR;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      ST_ERR: begin
        state_n = ST_DONE;
      end
      ST_DONE: begin
        grant_n = 2'b00;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      bc          <= 4'd0;
      rc          <= 2'd0;
      timer       <= 8'd0;
      grant_q     <= 2'b00;
      eng_start_q <= 1'b0;
      eng_in_q    <= 8'd0;
      res_valid_q <= 2'b00;
      res_data_q  <= 18'd0;
      res_idx_q   <= 2'd0;
      res_err_q   <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      rr_ptr      <= rr_ptr_n;
      bc          <= bc_n;
      rc          <= rc_n;
      timer       <= timer_n;
      grant_q     <= grant_n;
      eng_start_q <= eng_start_n;
      eng_in_q    <= eng_in_n;
      res_valid_q <= res_valid_n;
      res_data_q  <= res_data_n;
      res_idx_q   <= res_idx_n;
      res_err_q   <= res_err_n;
    end
  end

  assign bus.s0_busy   = busy_w[0];
  assign bus.s1_busy   = busy_w[1];
  assign bus.grant     = grant_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_in    = eng_in_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mv_job_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mv_job_arbiter : table-driven jobs plus directed corner sequences
// Revision: 1.0
// ============================================================================
module tb_mv_job_arbiter;
  localparam int TIMEOUT = 64;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  mv_job_arbiter_if bus ();

  mv_job_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               req;
    logic [0:11][7:0] b;
    int               lat;
    int               gap;
    logic [0:3][17:0] exp;
  } job_t;

  typedef struct {
    logic [7:0] b;
    logic [1:0] grant;
    int         cyc;
  } ebyte_t;

  typedef struct {
    logic [1:0]  owner;
    logic [17:0] data;
    logic [1:0]  idx;
    logic        err;
    int          cyc;
  } res_t;

  job_t   jobs [4];
  ebyte_t eng_q [$];
  res_t   res_q [$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Engine model state
  logic [7:0]  rx [12];
  logic [17:0] eres [4];
  int rx_n = 0, lat_cfg = 3, gap_cfg = 0, words_cfg = 4;
  int cnt_down = 0, words_left = 0, wi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got nothing expected an event", name);
  endtask

  function automatic void engine_compute();
    int d [3];
    int mn, mx, med;
    for (int r = 0; r < 3; r++) begin
      d[r] = 0;
      for (int c = 0; c < 3; c++)
        d[r] += int'($signed(rx[3*r+c])) * int'($signed(rx[9+c]));
    end
    mn  = (d[0] < d[1]) ? d[0] : d[1];
    mx  = (d[0] < d[1]) ? d[1] : d[0];
    med = (d[2] < mn) ? mn : ((d[2] > mx) ? mx : d[2]);
    for (int r = 0; r < 3; r++) eres[r] = 18'(d[r]);
    eres[3] = 18'(med);
  endfunction

  // One clock: observe outputs just after the edge, then drive the engine.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.eng_start) begin
      eng_q.push_back('{b: bus.eng_in, grant: bus.grant, cyc: cyc});
      rx[rx_n] = bus.eng_in;
      rx_n++;
      if (rx_n == 12) begin
        engine_compute();
        rx_n       = 0;
        cnt_down   = lat_cfg;
        words_left = words_cfg;
        wi         = 0;
      end
    end
    if (bus.res_valid != 2'b00)
      res_q.push_back('{owner: bus.res_valid, data: bus.res_data, idx: bus.res_idx,
                        err: bus.res_err, cyc: cyc});
    bus.eng_ready = 1'b0;
    if (words_left > 0) begin
      if (cnt_down == 0) begin
        bus.eng_ready = 1'b1;
        bus.eng_out   = eres[wi];
        wi++;
        words_left--;
        cnt_down = gap_cfg;
      end else begin
        cnt_down--;
      end
    end
  endtask

  task automatic load(input int req, input logic [0:11][7:0] b, input int first, input int last);
    logic [7:0] d;
    for (int i = first; i <= last; i++) begin
      if (i < 12) d = b[i];
      else        d = 8'h7E;
      if (req == 0) begin bus.s0_valid = 1'b1; bus.s0_data = d; end
      else          begin bus.s1_valid = 1'b1; bus.s1_data = d; end
      step();
    end
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
  endtask

  task automatic load_both(input logic [0:11][7:0] b0, input logic [0:11][7:0] b1);
    for (int i = 0; i < 12; i++) begin
      bus.s0_valid = 1'b1; bus.s0_data = b0[i];
      bus.s1_valid = 1'b1; bus.s1_data = b1[i];
      step();
    end
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (!(bus.grant == 2'b00 && !bus.s0_busy && !bus.s1_busy && words_left == 0) && k < max) begin
      step();
      k++;
    end
    if (k >= max) miss({name, "_idle_timeout"});
  endtask

  task automatic check_bytes(input string tag, input int req, input int k);
    ebyte_t e;
    int c0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (eng_q.size() == 0) begin miss($sformatf("%s_byte%0d", tag, i)); return; end
      e = eng_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, i), 32'(e.b), 32'(jobs[k].b[i]));
      if (i == 0) begin
        c0 = e.cyc;
        chk({tag, "_grant"}, 32'(e.grant), 32'(1 << req));
      end
      if (i == 11) chk({tag, "_feed_span"}, 32'(e.cyc - c0), 32'd11);
    end
  endtask

  task automatic check_res(input string tag, input int req, input int k, input int n);
    res_t r;
    for (int i = 0; i < n; i++) begin
      if (res_q.size() == 0) begin miss($sformatf("%s_res%0d", tag, i)); return; end
      r = res_q.pop_front();
      chk($sformatf("%s_res%0d_owner", tag, i), 32'(r.owner), 32'(1 << req));
      chk($sformatf("%s_res%0d_idx", tag, i), 32'(r.idx), 32'(i));
      chk($sformatf("%s_res%0d_data", tag, i), 32'(r.data), 32'(jobs[k].exp[i]));
      chk($sformatf("%s_res%0d_err", tag, i), 32'(r.err), 32'd0);
    end
  endtask

  task automatic check_job(input string tag, input int req, input int k);
    check_bytes(tag, req, k);
    check_res(tag, req, k, 4);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s0_busy"},   32'(bus.s0_busy),   32'd0);
    chk({tag, "_s1_busy"},   32'(bus.s1_busy),   32'd0);
    chk({tag, "_grant"},     32'(bus.grant),     32'd0);
    chk({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
    chk({tag, "_eng_in"},    32'(bus.eng_in),    32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_data"},  32'(bus.res_data),  32'd0);
    chk({tag, "_res_idx"},   32'(bus.res_idx),   32'd0);
    chk({tag, "_res_err"},   32'(bus.res_err),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r1, r2;
    int   k;

    // identity matrix, v = (5,-3,7)
    jobs[0].req = 0; jobs[0].lat = 3; jobs[0].gap = 0;
    jobs[0].b   = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd5, 8'(-3), 8'd7};
    jobs[0].exp = {18'd5, 18'(-3), 18'd7, 18'd5};
    // rows (2,1,0) (0,-1,3) (4,4,4), v = (1,2,3)
    jobs[1].req = 1; jobs[1].lat = 1; jobs[1].gap = 0;
    jobs[1].b   = {8'd2, 8'd1, 8'd0, 8'd0, 8'(-1), 8'd3, 8'd4, 8'd4, 8'd4, 8'd1, 8'd2, 8'd3};
    jobs[1].exp = {18'd4, 18'd7, 18'd24, 18'd7};
    // extremes, returned with 2-cycle gaps
    jobs[2].req = 0; jobs[2].lat = 0; jobs[2].gap = 2;
    jobs[2].b   = {8'(-128), 8'd0, 8'd0, 8'd0, 8'd127, 8'd0, 8'd1, 8'd1, 8'd1,
                   8'(-128), 8'd127, 8'(-1)};
    jobs[2].exp = {18'd16384, 18'd16129, 18'(-2), 18'd16129};
    // permutation rows, v = (-10,20,-30)
    jobs[3].req = 1; jobs[3].lat = 2; jobs[3].gap = 1;
    jobs[3].b   = {8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0,
                   8'(-10), 8'd20, 8'(-30)};
    jobs[3].exp = {18'(-30), 18'(-10), 18'd20, 18'(-10)};

    bus.s0_valid = 1'b0; bus.s0_data = 8'd0;
    bus.s1_valid = 1'b0; bus.s1_data = 8'd0;
    bus.eng_ready = 1'b0; bus.eng_out = 18'd0;

    step(); step();
    check_zero("reset");
    reset_n = 1'b1;
    step();

    // Table: single jobs, each requester alone
    for (int j = 0; j < 4; j++) begin
      lat_cfg = jobs[j].lat; gap_cfg = jobs[j].gap; words_cfg = 4;
      load(jobs[j].req, jobs[j].b, 0, 11);
      chk($sformatf("tbl%0d_busy_up", j),
          32'(jobs[j].req == 0 ? bus.s0_busy : bus.s1_busy), 32'd1);
      wait_idle($sformatf("tbl%0d", j), 300);
      check_job($sformatf("tbl%0d", j), jobs[j].req, j);
    end

    // Contention: s0 first, s0 reloads while s1 runs
    lat_cfg = 1; gap_cfg = 0; words_cfg = 4;
    load_both(jobs[0].b, jobs[1].b);
    k = 0;
    while (bus.grant != 2'b10 && k < 300) begin step(); k++; end
    if (k >= 300) miss("cont_a_grant_s1");
    load(0, jobs[2].b, 0, 11);
    chk("cont_a_reload_busy", 32'(bus.s0_busy), 32'd1);
    wait_idle("cont_a", 500);
    check_job("cont_a_s0", 0, 0);
    check_job("cont_a_s1", 1, 1);
    check_job("cont_a_s0r", 0, 2);

    // Contention again: round-robin now favours s1
    load_both(jobs[2].b, jobs[3].b);
    wait_idle("cont_b", 500);
    check_job("cont_b_s1", 1, 3);
    check_job("cont_b_s0", 0, 2);

    // Timeout after two words
    lat_cfg = 2; gap_cfg = 0; words_cfg = 2;
    load(0, jobs[0].b, 0, 11);
    wait_idle("tmo", 400);
    check_bytes("tmo", 0, 0);
    check_res("tmo", 0, 0, 1);
    if (res_q.size() < 2) miss("tmo_word1_and_err");
    else begin
      r1 = res_q.pop_front();
      r2 = res_q.pop_front();
      chk("tmo_w1_data",   32'(r1.data), 32'(jobs[0].exp[1]));
      chk("tmo_w1_idx",    32'(r1.idx),  32'd1);
      chk("tmo_err_owner", 32'(r2.owner), 32'd1);
      chk("tmo_err_flag",  32'(r2.err),   32'd1);
      chk("tmo_err_idx",   32'(r2.idx),   32'd2);
      chk("tmo_err_data",  32'(r2.data),  32'd0);
      chk("tmo_err_delay", 32'(r2.cyc - r1.cyc), 32'(TIMEOUT));
    end
    chk("tmo_extra_res", 32'(res_q.size()), 32'd0);
    bus.eng_ready = 1'b1; bus.eng_out = 18'h123;
    step(); step(); step();
    chk("tmo_stray_ready", 32'(res_q.size()), 32'd0);
    chk("tmo_stray_grant", 32'(bus.grant), 32'd0);

    // Overflow: 15 writes, then a write in the DONE cycle
    lat_cfg = 0; gap_cfg = 0; words_cfg = 4;
    load(1, jobs[1].b, 0, 14);
    chk("ovf_busy", 32'(bus.s1_busy), 32'd1);
    k = 0;
    while (!(bus.res_valid == 2'b10 && bus.res_idx == 2'd3) && k < 300) begin step(); k++; end
    if (k >= 300) miss("ovf_last_result");
    bus.s1_valid = 1'b1; bus.s1_data = 8'h55;
    step();
    bus.s1_valid = 1'b0;
    chk("ovf_busy_released", 32'(bus.s1_busy), 32'd0);
    chk("ovf_grant_released", 32'(bus.grant), 32'd0);
    check_job("ovf", 1, 1);
    load(1, jobs[3].b, 0, 10);
    chk("done_write_dropped", 32'(bus.s1_busy), 32'd0);
    load(1, jobs[3].b, 11, 11);
    chk("done_write_refill", 32'(bus.s1_busy), 32'd1);
    wait_idle("ovf2", 300);
    check_job("ovf2", 1, 3);

    // Reset at byte 5 of a feed
    lat_cfg = 3;
    load(0, jobs[0].b, 0, 11);
    k = 0;
    while (eng_q.size() < 6 && k < 100) begin step(); k++; end
    if (k >= 100) miss("rst_reach_byte5");
    chk("rst_pre_start", 32'(bus.eng_start), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    eng_q.delete(); res_q.delete();
    rx_n = 0; words_left = 0; bus.eng_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check_zero("rst_after");
    load(0, jobs[0].b, 0, 10);
    chk("rst_s0_empty", 32'(bus.s0_busy), 32'd0);
    load(0, jobs[0].b, 11, 11);
    wait_idle("rst_job", 300);
    check_job("rst_job", 0, 0);
    chk("rst_no_extra_bytes", 32'(eng_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
